// File: rtl/alu_pipe_nb.sv
// Two-stage valid/ready pipelined ALU: stage 1 registers operands, stage 2 registers result and flags.
// Optional unsigned saturation of ADD/SUB when ALU_SAT_EN is defined.
module alu_pipe_nb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOT   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    logic             s1_valid_r;
    logic [2:0]       s1_op_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             s1_cin_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] f_r;
    logic             cout_r;
    logic             zero_r;
    logic             ovf_r;

    logic             adv1_s;
    logic             adv2_s;
    logic [WIDTH+1:0] res_s;

    // Result packing: {cout, ovf, f}; cout/ovf always reflect raw arithmetic
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [2:0]       op_v,
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v,
        input logic             cin_v
    );
        logic [WIDTH:0]   sum_v;
        logic [WIDTH-1:0] beff_v;
        logic [WIDTH-1:0] f_v;
        logic             arith_v;
        logic             c_v;
        logic             o_v;
        if (op_v == OP_SUB) begin
            beff_v = ~b_v;
        end else begin
            beff_v = b_v;
        end
        sum_v   = {1'b0, a_v} + {1'b0, beff_v} + {{WIDTH{1'b0}}, cin_v};
        arith_v = (op_v == OP_ADD) || (op_v == OP_SUB);
        if (arith_v) begin
            c_v = sum_v[WIDTH];
            o_v = (a_v[WIDTH-1] == beff_v[WIDTH-1]) && (sum_v[WIDTH-1] != a_v[WIDTH-1]);
        end else begin
            c_v = 1'b0;
            o_v = 1'b0;
        end
        case (op_v)
            OP_AND:   f_v = a_v & b_v;
            OP_OR:    f_v = a_v | b_v;
            OP_XOR:   f_v = a_v ^ b_v;
            OP_NOT:   f_v = ~a_v;
            OP_ADD: begin
`ifdef ALU_SAT_EN
                if (sum_v[WIDTH]) begin
                    f_v = {WIDTH{1'b1}};
                end else begin
                    f_v = sum_v[WIDTH-1:0];
                end
`else
                f_v = sum_v[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
`ifdef ALU_SAT_EN
                if (!sum_v[WIDTH]) begin
                    f_v = {WIDTH{1'b0}};
                end else begin
                    f_v = sum_v[WIDTH-1:0];
                end
`else
                f_v = sum_v[WIDTH-1:0];
`endif
            end
            OP_PASSA: f_v = a_v;
            OP_PASSB: f_v = b_v;
            default:  f_v = {WIDTH{1'b0}};
        endcase
        return {c_v, o_v, f_v};
    endfunction

    assign adv2_s   = !out_valid_r || out_ready;
    assign adv1_s   = !s1_valid_r || adv2_s;
    assign res_s    = alu_eval(s1_op_r, s1_a_r, s1_b_r, s1_cin_r);

    assign in_ready  = adv1_s;
    assign out_valid = out_valid_r;
    assign f         = f_r;
    assign cout      = cout_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;

    // Stage 1: capture operands whenever the stage can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'b000;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_cin_r   <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_op_r  <= op;
                s1_a_r   <= a;
                s1_b_r   <= b;
                s1_cin_r <= cin;
            end
        end
    end

    // Stage 2: register result and flags; data only changes when a new beat moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            f_r         <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (adv2_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                f_r    <= res_s[WIDTH-1:0];
                ovf_r  <= res_s[WIDTH];
                cout_r <= res_s[WIDTH+1];
                zero_r <= (res_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
        end
    end

endmodule
